// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter.
// The single-cycle ALU writeback and the multi-cycle LSU writeback share one
// write port. The ALU normally has fixed priority. A starvation counter moves
// the arbiter into a one-cycle FORCE state that stalls the ALU and lets the
// waiting LSU result through. A busy scoreboard tracks destination registers
// that still have LSU results outstanding, so decode can detect RAW hazards.
module wb_port_arbiter #(
    parameter int XLEN         = 32,
    parameter int AW           = 5,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            reset,
    // ALU writeback path
    input  logic            alu_valid,
    input  logic [AW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_wdata,
    output logic            alu_stall,
    // LSU / multiply writeback path
    input  logic            lsu_valid,
    input  logic [AW-1:0]   lsu_rd,
    input  logic [XLEN-1:0] lsu_wdata,
    output logic            lsu_ready,
    // Issue of long-latency ops (sets scoreboard entries)
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    // Decode hazard lookup
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic            hazard1,
    output logic            hazard2,
    // Register file write port
    output logic            rf_wen,
    output logic [AW-1:0]   rf_rd,
    output logic [XLEN-1:0] rf_wdata
);

    localparam int NREG = 2 ** AW;
    localparam int CW   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic {
        NORMAL = 1'b0,
        FORCE  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [CW-1:0]      r_wait_cnt;
    logic [CW-1:0]      w_wait_next;
    logic               r_alu_stall;
    logic [NREG-1:0]    r_busy;
    logic [NREG-1:0]    w_set;
    logic [NREG-1:0]    w_clr;
    logic               w_lsu_ready;
    logic               w_lsu_gnt;
    logic               w_alu_gnt;
    logic               r_rf_wen;
    logic [AW-1:0]      r_rf_rd;
    logic [XLEN-1:0]    r_rf_wdata;

    // Grant decode: ALU wins in NORMAL, LSU is always accepted in FORCE.
    // Nothing is accepted while reset is held, so a request in flight at
    // reset must be presented again afterwards.
    always_comb begin
        w_lsu_ready = 1'b0;
        if (!reset) begin
            w_lsu_ready = (r_state == FORCE) ? 1'b1 : !alu_valid;
        end
        w_lsu_gnt = lsu_valid & w_lsu_ready;
        w_alu_gnt = alu_valid & (r_state == NORMAL) & !reset;
    end

    // Next-state and starvation counter update.
    always_comb begin
        w_state_next = r_state;
        w_wait_next  = r_wait_cnt;
        if (!lsu_valid || w_lsu_gnt) begin
            w_wait_next = '0;
        end else if (r_wait_cnt != LIMIT) begin
            w_wait_next = r_wait_cnt + 1'b1;
        end
        case (r_state)
            NORMAL: begin
                if (lsu_valid && !w_lsu_ready && (w_wait_next >= LIMIT)) begin
                    w_state_next = FORCE;
                end
            end
            FORCE: begin
                if (w_lsu_gnt || !lsu_valid) begin
                    w_state_next = NORMAL;
                end
            end
            default: w_state_next = NORMAL;
        endcase
    end

    // State, counter and registered ALU stall (tracks the FORCE state).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= NORMAL;
            r_wait_cnt  <= '0;
            r_alu_stall <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_wait_cnt  <= w_wait_next;
            r_alu_stall <= (w_state_next == FORCE);
        end
    end

    // Registered write port; grants are mutually exclusive by construction.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rf_wen   <= 1'b0;
            r_rf_rd    <= '0;
            r_rf_wdata <= '0;
        end else if (w_alu_gnt) begin
            r_rf_wen   <= (alu_rd != '0);
            r_rf_rd    <= alu_rd;
            r_rf_wdata <= alu_wdata;
        end else if (w_lsu_gnt) begin
            r_rf_wen   <= (lsu_rd != '0);
            r_rf_rd    <= lsu_rd;
            r_rf_wdata <= lsu_wdata;
        end else begin
            r_rf_wen   <= 1'b0;
        end
    end

    // Per-register set/clear decode; x0 can never become busy.
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_busy_dec
            if (gi == 0) begin : g_zero
                assign w_set[gi] = 1'b0;
                assign w_clr[gi] = 1'b0;
            end else begin : g_reg
                assign w_set[gi] = iss_valid & (iss_rd == AW'(gi));
                assign w_clr[gi] = w_lsu_gnt & (lsu_rd == AW'(gi));
            end
        end
    endgenerate

    // Busy scoreboard: a set in the same cycle as a clear wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= (r_busy & ~w_clr) | w_set;
        end
    end

    assign lsu_ready = w_lsu_ready;
    assign alu_stall = r_alu_stall;
    assign hazard1   = r_busy[rs1];
    assign hazard2   = r_busy[rs2];
    assign rf_wen    = r_rf_wen;
    assign rf_rd     = r_rf_rd;
    assign rf_wdata  = r_rf_wdata;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: expected register-file writes are
// queued when stimulus is driven and compared when the write port updates.
module tb_wb_port_arbiter;

    logic        clk;
    logic        reset;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_wdata;
    logic        alu_stall;
    logic        lsu_valid;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_wdata;
    logic        lsu_ready;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        hazard1;
    logic        hazard2;
    logic        rf_wen;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        wen;
        logic [4:0]  rd;
        logic [31:0] wdata;
        bit          chk_data;
    } wr_t;

    wr_t exp_q[$];

    wb_port_arbiter #(
        .XLEN(32),
        .AW(5),
        .STARVE_LIMIT(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .alu_valid(alu_valid),
        .alu_rd(alu_rd),
        .alu_wdata(alu_wdata),
        .alu_stall(alu_stall),
        .lsu_valid(lsu_valid),
        .lsu_rd(lsu_rd),
        .lsu_wdata(lsu_wdata),
        .lsu_ready(lsu_ready),
        .iss_valid(iss_valid),
        .iss_rd(iss_rd),
        .rs1(rs1),
        .rs2(rs2),
        .hazard1(hazard1),
        .hazard2(hazard2),
        .rf_wen(rf_wen),
        .rf_rd(rf_rd),
        .rf_wdata(rf_wdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count a comparison and report it when observed differs from expected.
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    // Queue the expected write for this cycle, advance one clock, then pop
    // and compare against the write port.
    task automatic tick(input logic wen, input logic [4:0] rd, input logic [31:0] wd,
                        input bit chk_data);
        wr_t e;
        e.wen      = wen;
        e.rd       = rd;
        e.wdata    = wd;
        e.chk_data = chk_data;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("rf_wen", {63'd0, rf_wen}, {63'd0, e.wen});
        if (e.chk_data) begin
            check("rf_rd", {59'd0, rf_rd}, {59'd0, e.rd});
            check("rf_wdata", {32'd0, rf_wdata}, {32'd0, e.wdata});
        end
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
        iss_valid = 1'b0;
    endtask

    initial begin
        // Reset held two cycles with every request active.
        reset = 1'b1;
        alu_valid = 1'b1; alu_rd = 5'd1; alu_wdata = 32'h1;
        lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_wdata = 32'h2;
        iss_valid = 1'b1; iss_rd = 5'd3;
        rs1 = 5'd3; rs2 = 5'd2;
        #1;
        check("rst_lsu_ready", {63'd0, lsu_ready}, 64'd0);
        for (int i = 0; i < 2; i++) begin
            tick(1'b0, 5'd0, 32'd0, 1'b1);
            check("rst_alu_stall", {63'd0, alu_stall}, 64'd0);
            check("rst_hazard1", {63'd0, hazard1}, 64'd0);
            check("rst_hazard2", {63'd0, hazard2}, 64'd0);
            check("rst_lsu_ready", {63'd0, lsu_ready}, 64'd0);
        end
        reset = 1'b0;
        idle_inputs();
        rs1 = 5'd0; rs2 = 5'd0;
        tick(1'b0, 5'd0, 32'd0, 1'b1);

        // ALU-only writes, a hold cycle, then a write to x0.
        alu_valid = 1'b1; alu_rd = 5'd5; alu_wdata = 32'hDEADBEEF;
        #1;
        check("alu_lsu_ready", {63'd0, lsu_ready}, 64'd0);
        tick(1'b1, 5'd5, 32'hDEADBEEF, 1'b1);
        alu_valid = 1'b0;
        tick(1'b0, 5'd5, 32'hDEADBEEF, 1'b1);
        alu_valid = 1'b1; alu_rd = 5'd0; alu_wdata = 32'h55;
        tick(1'b0, 5'd0, 32'd0, 1'b0);
        alu_valid = 1'b0;
        tick(1'b0, 5'd0, 32'd0, 1'b0);

        // Contention: ALU first, LSU the following cycle.
        alu_valid = 1'b1; alu_rd = 5'd6; alu_wdata = 32'hA5;
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_wdata = 32'h11;
        #1;
        check("cont_lsu_ready_lo", {63'd0, lsu_ready}, 64'd0);
        tick(1'b1, 5'd6, 32'hA5, 1'b1);
        alu_valid = 1'b0;
        #1;
        check("cont_lsu_ready_hi", {63'd0, lsu_ready}, 64'd1);
        tick(1'b1, 5'd7, 32'h11, 1'b1);
        lsu_valid = 1'b0;
        tick(1'b0, 5'd0, 32'd0, 1'b0);

        // Starvation: four lost cycles, then one FORCE cycle grants the LSU.
        alu_valid = 1'b1; alu_rd = 5'd10; alu_wdata = 32'hAAAA0000;
        lsu_valid = 1'b1; lsu_rd = 5'd9;  lsu_wdata = 32'h1234;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("starve_lsu_ready", {63'd0, lsu_ready}, 64'd0);
            check("starve_alu_stall", {63'd0, alu_stall}, 64'd0);
            tick(1'b1, 5'd10, 32'hAAAA0000, 1'b1);
        end
        check("force_alu_stall", {63'd0, alu_stall}, 64'd1);
        check("force_lsu_ready", {63'd0, lsu_ready}, 64'd1);
        tick(1'b1, 5'd9, 32'h1234, 1'b1);
        lsu_valid = 1'b0;
        #1;
        check("resume_alu_stall", {63'd0, alu_stall}, 64'd0);
        tick(1'b1, 5'd10, 32'hAAAA0000, 1'b1);
        alu_valid = 1'b0;
        tick(1'b0, 5'd0, 32'd0, 1'b0);

        // Scoreboard set, lookup without bypass, clear on LSU grant.
        iss_valid = 1'b1; iss_rd = 5'd3; rs1 = 5'd3; rs2 = 5'd4;
        #1;
        check("sb_no_bypass_set", {63'd0, hazard1}, 64'd0);
        tick(1'b0, 5'd0, 32'd0, 1'b0);
        iss_valid = 1'b0;
        #1;
        check("sb_hazard1_set", {63'd0, hazard1}, 64'd1);
        check("sb_hazard2_clr", {63'd0, hazard2}, 64'd0);
        lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_wdata = 32'h33;
        #1;
        check("sb_no_bypass_clr", {63'd0, hazard1}, 64'd1);
        tick(1'b1, 5'd3, 32'h33, 1'b1);
        lsu_valid = 1'b0;
        #1;
        check("sb_hazard1_cleared", {63'd0, hazard1}, 64'd0);

        // Same-cycle set and clear of x3: set wins.
        iss_valid = 1'b1; iss_rd = 5'd3;
        tick(1'b0, 5'd0, 32'd0, 1'b0);
        lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_wdata = 32'h44;
        tick(1'b1, 5'd3, 32'h44, 1'b1);
        idle_inputs();
        #1;
        check("sb_set_wins", {63'd0, hazard1}, 64'd1);
        lsu_valid = 1'b1; lsu_wdata = 32'h45;
        tick(1'b1, 5'd3, 32'h45, 1'b1);
        lsu_valid = 1'b0;
        #1;
        check("sb_cleanup", {63'd0, hazard1}, 64'd0);

        // Issue to x0 never marks it busy.
        iss_valid = 1'b1; iss_rd = 5'd0; rs1 = 5'd0;
        tick(1'b0, 5'd0, 32'd0, 1'b0);
        iss_valid = 1'b0;
        check("sb_x0_never_busy", {63'd0, hazard1}, 64'd0);

        // Reset while in FORCE with x8 busy.
        iss_valid = 1'b1; iss_rd = 5'd8;
        tick(1'b0, 5'd0, 32'd0, 1'b0);
        iss_valid = 1'b0; rs1 = 5'd8;
        #1;
        check("pre_rst_hazard", {63'd0, hazard1}, 64'd1);
        alu_valid = 1'b1; alu_rd = 5'd11; alu_wdata = 32'hB0B0;
        lsu_valid = 1'b1; lsu_rd = 5'd12; lsu_wdata = 32'h77;
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 5'd11, 32'hB0B0, 1'b1);
        end
        check("pre_rst_force", {63'd0, alu_stall}, 64'd1);
        reset = 1'b1;
        tick(1'b0, 5'd0, 32'd0, 1'b1);
        check("rst_force_alu_stall", {63'd0, alu_stall}, 64'd0);
        check("rst_force_busy", {63'd0, hazard1}, 64'd0);
        check("rst_force_lsu_ready", {63'd0, lsu_ready}, 64'd0);
        reset = 1'b0;
        // The counter restarted from zero: four more lost cycles before FORCE.
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 5'd11, 32'hB0B0, 1'b1);
            check("post_rst_no_force", {63'd0, alu_stall}, 64'd0);
        end
        tick(1'b1, 5'd11, 32'hB0B0, 1'b1);
        check("post_rst_force", {63'd0, alu_stall}, 64'd1);
        tick(1'b1, 5'd12, 32'h77, 1'b1);
        idle_inputs();
        tick(1'b0, 5'd0, 32'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the register file's single write port between the single-cycle ALU writeback path and the multi-cycle load/multiply (LSU) writeback path.
- Keeps a busy scoreboard of destination registers with LSU results outstanding, so decode can detect RAW hazards.
- Guarantees LSU forward progress with a starvation counter that stalls the ALU pipeline.
- Sits between the execute/memory stages and the register file write port.

Parameters:
- XLEN, 32, data width of write data.
- AW, 5, register index width (2^AW architectural registers; x0 hardwired to zero).
- STARVE_LIMIT, 4, consecutive lost LSU arbitration cycles before the FORCE state is entered (legal range >= 1).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- alu_valid  in  1  ALU writeback request.
- alu_rd  in  AW  ALU destination register.
- alu_wdata  in  XLEN  ALU result.
- alu_stall  out  1  registered; high = upstream must hold the ALU request stable and not advance.
- lsu_valid  in  1  LSU writeback request; held until accepted.
- lsu_rd  in  AW  LSU destination register.
- lsu_wdata  in  XLEN  LSU result.
- lsu_ready  out  1  combinational accept for the LSU request.
- iss_valid  in  1  long-latency op issued this cycle.
- iss_rd  in  AW  destination of the issued op.
- rs1  in  AW  decode source 1.
- rs2  in  AW  decode source 2.
- hazard1  out  1  combinational; rs1 busy.
- hazard2  out  1  combinational; rs2 busy.
- rf_wen  out  1  registered write enable to the register file.
- rf_rd  out  AW  registered write index.
- rf_wdata  out  XLEN  registered write data.

Behaviour:
- Reset values: state=NORMAL, wait_cnt=0, busy=0 for all registers, rf_wen=0, rf_rd=0, rf_wdata=0, alu_stall=0.
- Reset mid-operation drops any in-flight grant. The LSU must re-present its request after reset.

State machine and arbitration:
- States: NORMAL, FORCE.
- NORMAL: lsu_ready = !alu_valid, so the ALU has fixed priority. ALU is granted when alu_valid=1.
- FORCE: lsu_ready=1 and alu_stall=1. An ALU request present in FORCE is not written; upstream holds it.
- LSU grant (lsu_gnt) = lsu_valid & lsu_ready.
- Write port latency is 1 cycle. On the cycle after a grant: rf_wen=1, rf_rd and rf_wdata take the granted requester's values.
  - If the granted rd==0, rf_wen=0.
  - With no grant, rf_wen=0 and rf_rd/rf_wdata hold their previous values.
- wait_cnt:
  - Increments (saturating) on each cycle with lsu_valid & !lsu_ready.
  - Clears on lsu_gnt or when lsu_valid=0.
- NORMAL->FORCE: the cycle the incremented wait_cnt reaches STARVE_LIMIT. alu_stall rises together with the state change (registered).
- FORCE->NORMAL: on lsu_gnt, or if lsu_valid=0. wait_cnt clears. alu_stall falls the next cycle.
- lsu_valid=1 in FORCE is granted in the first FORCE cycle. FORCE therefore lasts exactly 1 cycle when the LSU holds its request.

Scoreboard:
- iss_valid with iss_rd!=0 sets busy[iss_rd] at the next posedge.
- lsu_gnt clears busy[lsu_rd] at the next posedge.
- Set and clear of the same register in the same cycle: set wins.
- busy[0] is always 0.
- hazard1 = busy[rs1], hazard2 = busy[rs2]. There is no bypass of same-cycle set or clear: a lookup reflects the registered busy state only.
- ALU writes never touch the scoreboard.

Test Plan:
- Reset: assert reset 2 cycles with all valids high -> rf_wen=0, alu_stall=0, hazard1/2=0, lsu_ready=0 while alu_valid=1.
- ALU-only: alu_valid=1, rd=5, wdata=0xDEADBEEF -> next cycle rf_wen=1, rf_rd=5, rf_wdata=0xDEADBEEF. Repeat with rd=0 -> rf_wen=0.
- Contention: alu_valid and lsu_valid both high for 1 cycle (lsu rd=7, 0x11), then alu_valid=0 -> ALU written first. LSU written the following cycle, lsu_ready low then high.
- Starvation (STARVE_LIMIT=4): alu_valid held high, lsu_valid high (rd=9, 0x1234) -> lsu_ready low for 4 cycles. Cycle 5: alu_stall=1, lsu_ready=1, grant. Cycle 6: rf_rd=9, rf_wdata=0x1234, alu_stall=0, ALU resumes.
- Scoreboard: iss_valid, rd=3 -> next cycle rs1=3 gives hazard1=1. LSU writes rd=3 -> hazard1=0 one cycle after grant. Same-cycle issue rd=3 with LSU grant rd=3 -> busy[3] stays 1. iss_rd=0 -> never busy.
- Reset during FORCE -> next cycle state NORMAL, alu_stall=0, wait_cnt=0, busy cleared.
